// File: rtl/cpu_fetch.sv
// cpu_fetch: in-order instruction fetch with a small response FIFO.
// Requests are credit-limited so that buffered plus outstanding fetches
// never exceed DEPTH. A redirect flushes the FIFO and marks every in-flight
// response for discard.
// Optional build macro CPU_FETCH_MISALIGN_EN: a misaligned redirect target
// produces a single fault entry (if_fault = 10) instead of being aligned.
//
// state | meaning
// RUN   | fetching and presenting buffered entries
// FAULT | misaligned fault entry presented, no requests issued
// IDLE  | fault entry consumed, waiting for a redirect
module cpu_fetch #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic [1:0]  if_fault
);

   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = AW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]   ONE_C   = CW'(1);
   localparam logic [AW-1:0]   PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FAULT = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;

   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic          err_mem_q   [DEPTH];

   logic [31:0]   redir_pc;
   logic          redir_mis;
   logic          credit;
   logic          req_fire;
   logic          resp_dec;
   logic          push;
   logic          pop;
   logic          fault_pop;

`ifdef CPU_FETCH_MISALIGN_EN
   localparam logic [31:0] NOP = 32'h0000_0013;
   assign redir_pc  = redirect_pc;
   assign redir_mis = |redirect_pc[1:0];
`else
   // Low address bits are dropped so a misaligned target can never be fetched.
   assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
   assign redir_mis = 1'b0;
`endif

   // Request credit, handshakes and the entry presented to decode
   always_comb begin
      credit         = ({1'b0, count_q} + {1'b0, outst_q}) < {1'b0, DEPTH_C};
      imem_req_valid = !rst && (state_q == ST_RUN) && !redirect_valid && credit;
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      resp_dec       = imem_resp_valid && (outst_q != '0);
      push           = !rst && imem_resp_valid && (discard_q == '0) && !redirect_valid;

      if_valid = 1'b0;
      if_pc    = '0;
      if_instr = '0;
      if_fault = 2'b00;
      if (!rst && !redirect_valid) begin
         if ((state_q == ST_RUN) && (count_q != '0)) begin
            if_valid = 1'b1;
            if_pc    = pc_mem_q[rd_ptr_q];
            if_instr = instr_mem_q[rd_ptr_q];
            if_fault = {1'b0, err_mem_q[rd_ptr_q]};
         end
`ifdef CPU_FETCH_MISALIGN_EN
         else if (state_q == ST_FAULT) begin
            // fetch_pc holds the misaligned redirect target while faulted
            if_valid = 1'b1;
            if_pc    = fetch_pc_q;
            if_instr = NOP;
            if_fault = 2'b10;
         end
`endif
      end

      pop       = if_valid && if_ready && (state_q == ST_RUN);
      fault_pop = if_valid && if_ready && (state_q == ST_FAULT);
   end

   // Next-state for pcs, counters, pointers and FSM; redirect has priority
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (redirect_valid) begin
         fetch_pc_d = redir_pc;
         resp_pc_d  = redir_pc;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         outst_d    = outst_q - (resp_dec ? ONE_C : '0);
         // Everything still in flight after this edge belongs to the old path.
         discard_d  = outst_d;
         state_d    = redir_mis ? ST_FAULT : ST_RUN;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         outst_d = outst_q + (req_fire ? ONE_C : '0) - (resp_dec ? ONE_C : '0);
         if (imem_resp_valid && (discard_q != '0)) begin
            discard_d = discard_q - ONE_C;
         end
         if (push) begin
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            resp_pc_d = resp_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         count_d = count_q + (push ? ONE_C : '0) - (pop ? ONE_C : '0);
         if (fault_pop) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are only observed through count, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_resp_data;
         err_mem_q[wr_ptr_q]   <= imem_resp_err;
      end
   end

   // The credit rule must keep a push from ever landing on a full FIFO
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && (count_q == DEPTH_C)));
      end
   end

endmodule
